// File: rtl/trng_fifo_sequencer_if.sv
// Signal bundle between the TRNG/FIFO/UART sequencer and its surroundings:
// TRNG fill path, FIFO_OUT drain path, UART transmitter and CPU status.
interface trng_fifo_sequencer_if;
   logic        trng_valid;
   logic [31:0] trng_data;
   logic        fifo1_full;
   logic        fifo1_wr_en;
   logic [31:0] fifo1_wr_data;
   logic        start;
   logic        fifo2_full;
   logic        fifo2_empty;
   logic [31:0] fifo2_rd_data;
   logic        fifo2_rd_en;
   logic        uart_tx_busy;
   logic        uart_tx_start;
   logic [7:0]  uart_tx_data;
   logic        busy;
   logic        done;
   logic [15:0] words_sent;

   // Environment side: TRNG source, both FIFOs, UART and CPU control
   modport master (
      output trng_valid, trng_data, fifo1_full, start, fifo2_full, fifo2_empty,
             fifo2_rd_data, uart_tx_busy,
      input  fifo1_wr_en, fifo1_wr_data, fifo2_rd_en, uart_tx_start, uart_tx_data,
             busy, done, words_sent
   );

   // Sequencer side
   modport slave (
      input  trng_valid, trng_data, fifo1_full, start, fifo2_full, fifo2_empty,
             fifo2_rd_data, uart_tx_busy,
      output fifo1_wr_en, fifo1_wr_data, fifo2_rd_en, uart_tx_start, uart_tx_data,
             busy, done, words_sent
   );
endinterface

// File: rtl/trng_fifo_sequencer.sv
// TRNG FIFO sequencer: pushes TRNG words into FIFO_IN, and on a CPU load request
// drains FIFO_OUT word by word, sending each word as four bytes over the UART.
module trng_fifo_sequencer #(
   parameter bit          LSB_FIRST = 1'b1,
   parameter logic [15:0] MAX_WORDS = 16'hFFFF
) (
   input logic                  clk,
   input logic                  rst,
   trng_fifo_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_ARMED, S_POP, S_LATCH, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE, S_NEXT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        start_q;
   logic        wr_en_q;
   logic [31:0] wr_data_q;
   logic [2:0]  idx_q, idx_d;
   logic        wt_q, wt_d;
   logic [31:0] sr_q;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [15:0] words_q, words_d;
   logic        start_rise;
   logic [1:0]  lane;
   logic [7:0]  sel_byte;

   assign start_rise = bus.start & ~start_q;
   // Byte lane of the current index; MSB-first order walks the lanes downwards.
   assign lane       = LSB_FIRST ? idx_q[1:0] : (2'd3 - idx_q[1:0]);
   assign sel_byte   = sr_q[{lane, 3'b000} +: 8];

   // Fill path: one registered push per accepted TRNG word, independent of the drain FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= bus.trng_valid & ~bus.fifo1_full;
         if (bus.trng_valid && !bus.fifo1_full) wr_data_q <= bus.trng_data;
      end
   end

   // Drain FSM state, byte index, UART strobe/data and word counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         idx_q      <= '0;
         wt_q       <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= bus.start;
         idx_q      <= idx_d;
         wt_q       <= wt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         words_q    <= words_d;
      end
   end

   // Word shift register: loaded in LATCH, the cycle the popped word is on the FIFO read port
   always_ff @(posedge clk) begin
      if (state_q == S_LATCH) sr_q <= bus.fifo2_rd_data;
   end

   // Drain FSM next-state logic; the UART strobe is registered so it is a clean one-cycle pulse
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      wt_d       = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      words_d    = words_q;
      case (state_q)
         S_IDLE:      if (start_rise) state_d = S_ARMED;
         S_ARMED: begin
            if (bus.fifo2_full)  state_d = S_POP;
            else if (!bus.start) state_d = S_IDLE;
         end
         S_POP: begin
            idx_d   = '0;
            state_d = S_LATCH;
         end
         S_LATCH:     state_d = S_SEND;
         S_SEND: begin
            if (!bus.uart_tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = sel_byte;
               state_d    = S_WAIT_BUSY;
            end
         end
         // Give the UART up to two cycles to raise busy, so a slow busy cannot cause a double send
         S_WAIT_BUSY: begin
            if (bus.uart_tx_busy || wt_q) state_d = S_WAIT_IDLE;
            else                          wt_d    = 1'b1;
         end
         S_WAIT_IDLE: begin
            if (!bus.uart_tx_busy) begin
               idx_d   = idx_q + 3'd1;
               state_d = (idx_q == 3'd3) ? S_NEXT : S_SEND;
            end
         end
         S_NEXT: begin
            if (words_q != MAX_WORDS) words_d = words_q + 16'd1;
            state_d = bus.fifo2_empty ? S_DONE : S_POP;
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   assign bus.fifo1_wr_en   = wr_en_q;
   assign bus.fifo1_wr_data = wr_data_q;
   assign bus.fifo2_rd_en   = (state_q == S_POP) & ~bus.fifo2_empty;
   assign bus.uart_tx_start = tx_start_q;
   assign bus.uart_tx_data  = tx_data_q;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = (state_q == S_DONE);
   assign bus.words_sent    = words_q;

endmodule

// File: tb/tb_trng_fifo_sequencer.sv
// Directed bench for trng_fifo_sequencer. Two instances share all inputs: one
// LSB-first (drives the FIFO/UART models) and one MSB-first (bytes recorded only).
module tb_trng_fifo_sequencer;
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   trng_fifo_sequencer_if bus ();
   trng_fifo_sequencer_if bus_m ();

   trng_fifo_sequencer #(.LSB_FIRST(1'b1), .MAX_WORDS(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   trng_fifo_sequencer #(.LSB_FIRST(1'b0), .MAX_WORDS(16'hFFFF)) dut_m (
      .clk(clk), .rst(rst), .bus(bus_m)
   );

   assign bus_m.trng_valid    = bus.trng_valid;
   assign bus_m.trng_data     = bus.trng_data;
   assign bus_m.fifo1_full    = bus.fifo1_full;
   assign bus_m.start         = bus.start;
   assign bus_m.fifo2_full    = bus.fifo2_full;
   assign bus_m.fifo2_empty   = bus.fifo2_empty;
   assign bus_m.fifo2_rd_data = bus.fifo2_rd_data;
   assign bus_m.uart_tx_busy  = bus.uart_tx_busy;

   // FIFO_OUT model: words appended by the stimulus, popped with one-cycle read latency
   logic [31:0] fmem [16];
   int nload = 0;
   int rp    = 0;
   int pops  = 0;
   always @(posedge clk) begin
      if (bus.fifo2_rd_en && rp < nload) begin
         bus.fifo2_rd_data <= fmem[4'(rp)];
         rp   <= rp + 1;
         pops <= pops + 1;
      end
   end
   assign bus.fifo2_empty = (rp == nload);

   // UART model: busy for 10 cycles per byte, plus a forced-busy override
   logic [3:0] ucnt = '0;
   logic       force_busy = 1'b0;
   logic [7:0] bmem   [64];
   logic [7:0] bmem_m [64];
   int nb = 0;
   int ndone = 0;
   int nviol_rd = 0;
   int nviol_tx = 0;
   always @(posedge clk) begin
      if (bus.uart_tx_start) begin
         bmem[6'(nb)]   <= bus.uart_tx_data;
         bmem_m[6'(nb)] <= bus_m.uart_tx_data;
         nb   <= nb + 1;
         ucnt <= 4'd10;
      end else if (ucnt != 4'd0) begin
         ucnt <= ucnt - 4'd1;
      end
      if (bus.done) ndone <= ndone + 1;
      if (bus.fifo2_rd_en && bus.fifo2_empty) nviol_rd <= nviol_rd + 1;
      if (bus.uart_tx_start && bus.uart_tx_busy) nviol_tx <= nviol_tx + 1;
   end
   assign bus.uart_tx_busy = (ucnt != 4'd0) || force_busy;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [31:0] w);
      fmem[4'(nload)] = w;
      nload = nload + 1;
   endtask

   task automatic wait_done(input string tag);
      int base;
      int n;
      base = ndone;
      n    = 0;
      while (ndone == base && n < 1000) begin
         tick(1);
         n++;
      end
      check(tag, 32'(ndone != base), 32'd1);
   endtask

   // Expected bytes are given left-aligned in send order: first byte in s[95:88].
   task automatic check_stream(input string tag, input int base, input int n,
                               input logic [95:0] s, input bit from_msb_dut);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_b%0d", tag, i),
               32'(from_msb_dut ? bmem_m[6'(base + i)] : bmem[6'(base + i)]),
               32'(s[95 - 8*i -: 8]));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cnt, b0, p0, d0, b1, p1, n;
      bus.trng_valid = 1'b1;
      bus.trng_data  = 32'hFFFF_0001;
      bus.fifo1_full = 1'b0;
      bus.start      = 1'b0;
      bus.fifo2_full = 1'b0;
      rst            = 1'b1;
      tick(3);
      check("rst_wr_en",    32'(bus.fifo1_wr_en),   32'd0);
      check("rst_wr_data",  bus.fifo1_wr_data,       32'd0);
      check("rst_rd_en",    32'(bus.fifo2_rd_en),   32'd0);
      check("rst_tx_start", 32'(bus.uart_tx_start), 32'd0);
      check("rst_tx_data",  32'(bus.uart_tx_data),  32'd0);
      check("rst_busy",     32'(bus.busy),          32'd0);
      check("rst_done",     32'(bus.done),          32'd0);
      check("rst_words",    32'(bus.words_sent),    32'd0);

      // Fill path
      rst = 1'b0;
      bus.trng_data = 32'hDEADBEEF;
      tick(1);
      check("fill_wr_en",   32'(bus.fifo1_wr_en), 32'd1);
      check("fill_wr_data", bus.fifo1_wr_data,     32'hDEADBEEF);
      bus.fifo1_full = 1'b1;
      bus.trng_data  = 32'h12345678;
      tick(1);
      check("fill_full_drop", 32'(bus.fifo1_wr_en), 32'd0);
      bus.fifo1_full = 1'b0;
      bus.trng_valid = 1'b0;
      tick(1);
      check("fill_no_valid", 32'(bus.fifo1_wr_en), 32'd0);
      bus.trng_valid = 1'b1;
      bus.trng_data  = 32'hA5A50F0F;
      tick(1);
      check("fill2_wr_en",   32'(bus.fifo1_wr_en), 32'd1);
      check("fill2_wr_data", bus.fifo1_wr_data,     32'hA5A50F0F);
      bus.trng_valid = 1'b0;
      tick(1);

      // Single-word drain, LSB first, with minimum latency
      load(32'h11223344);
      bus.fifo2_full = 1'b1;
      b0 = nb; p0 = pops; d0 = ndone;
      bus.start = 1'b1;
      tick(1);
      check("single_armed_busy", 32'(bus.busy), 32'd1);
      lat = 0;
      while (!bus.uart_tx_start && lat < 20) begin
         tick(1);
         lat++;
      end
      check("single_first_latency", 32'(lat), 32'd4);
      wait_done("single_done_seen");
      check_stream("single", b0, 4, {32'h44332211, 64'h0}, 1'b0);
      check("single_nbytes", 32'(nb - b0),    32'd4);
      check("single_pops",   32'(pops - p0),  32'd1);
      check("single_ndone",  32'(ndone - d0), 32'd1);
      check("single_words",  32'(bus.words_sent), 32'd1);

      // Multi-word drain: three words, checked in both byte orders
      bus.start = 1'b0;
      bus.fifo2_full = 1'b0;
      tick(2);
      load(32'hA1B2C3D4);
      load(32'h01020304);
      load(32'hCAFEF00D);
      bus.fifo2_full = 1'b1;
      b0 = nb; p0 = pops;
      bus.start = 1'b1;
      wait_done("multi_done_seen");
      check_stream("multi_msb", b0, 12, 96'hA1B2C3D4_01020304_CAFEF00D, 1'b1);
      check_stream("multi_lsb", b0, 12, 96'hD4C3B2A1_04030201_0DF0FECA, 1'b0);
      check("multi_pops",    32'(pops - p0),        32'd3);
      check("multi_words",   32'(bus.words_sent),   32'd4);
      check("multi_words_m", 32'(bus_m.words_sent), 32'd4);
      check("multi_rd_empty", 32'(nviol_rd),        32'd0);

      // Backpressure: UART busy for 50 cycles before the first byte
      bus.start = 1'b0;
      bus.fifo2_full = 1'b0;
      force_busy = 1'b1;
      tick(2);
      load(32'h55667788);
      bus.fifo2_full = 1'b1;
      b0 = nb;
      bus.start = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (bus.uart_tx_start) cnt++;
      end
      check("bp_no_start", 32'(cnt),      32'd0);
      check("bp_busy",     32'(bus.busy), 32'd1);
      force_busy = 1'b0;
      wait_done("bp_done_seen");
      check_stream("bp", b0, 4, {32'h88776655, 64'h0}, 1'b0);
      check("bp_nbytes", 32'(nb - b0),   32'd4);
      check("bp_tx_busy", 32'(nviol_tx), 32'd0);

      // Cancel: start rises then falls with FIFO_OUT not full
      bus.start = 1'b0;
      bus.fifo2_full = 1'b0;
      tick(2);
      d0 = ndone; p0 = pops;
      bus.start = 1'b1;
      tick(1);
      check("cancel_armed", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      tick(1);
      check("cancel_idle", 32'(bus.busy), 32'd0);
      tick(3);
      check("cancel_no_done", 32'(ndone - d0), 32'd0);
      check("cancel_no_pop",  32'(pops - p0),  32'd0);

      // Second start edge while waiting in SEND is ignored
      force_busy = 1'b1;
      load(32'h0A0B0C0D);
      bus.fifo2_full = 1'b1;
      b0 = nb; p0 = pops; d0 = ndone;
      bus.start = 1'b1;
      tick(6);
      bus.start = 1'b0;
      tick(1);
      bus.start = 1'b1;
      tick(1);
      force_busy = 1'b0;
      wait_done("ign_done_seen");
      tick(4);
      check("ign_idle_after", 32'(bus.busy),    32'd0);
      check("ign_pops",       32'(pops - p0),   32'd1);
      check("ign_ndone",      32'(ndone - d0),  32'd1);
      check_stream("ign", b0, 4, {32'h0D0C0B0A, 64'h0}, 1'b0);

      // Reset after the second byte of a word
      bus.start = 1'b0;
      tick(2);
      load(32'hDEADC0DE);
      b0 = nb;
      bus.start = 1'b1;
      n = 0;
      while ((nb - b0) < 2 && n < 200) begin
         tick(1);
         n++;
      end
      check("mrst_two_bytes", 32'(nb - b0), 32'd2);
      rst = 1'b1;
      bus.start = 1'b0;
      tick(1);
      check("mrst_busy",     32'(bus.busy),          32'd0);
      check("mrst_tx_start", 32'(bus.uart_tx_start), 32'd0);
      check("mrst_tx_data",  32'(bus.uart_tx_data),  32'd0);
      check("mrst_rd_en",    32'(bus.fifo2_rd_en),   32'd0);
      check("mrst_done",     32'(bus.done),          32'd0);
      check("mrst_words",    32'(bus.words_sent),    32'd0);
      check("mrst_wr_data",  bus.fifo1_wr_data,       32'd0);
      b1 = nb; p1 = pops;
      tick(1);
      rst = 1'b0;
      tick(20);
      check("mrst_no_bytes", 32'(nb - b1),   32'd0);
      check("mrst_no_pops",  32'(pops - p1), 32'd0);
      check("mrst_idle",     32'(bus.busy),  32'd0);
      load(32'h12345678);
      bus.fifo2_full = 1'b1;
      b0 = nb; p0 = pops;
      bus.start = 1'b1;
      wait_done("restart_done_seen");
      check_stream("restart", b0, 4, {32'h78563412, 64'h0}, 1'b0);
      check("restart_words", 32'(bus.words_sent), 32'd1);
      check("restart_pops",  32'(pops - p0),      32'd1);
      bus.start = 1'b0;
      tick(2);

      check("final_rd_empty", 32'(nviol_rd), 32'd0);
      check("final_tx_busy",  32'(nviol_tx), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
